mmu_mem_return_router: RTL and testbench

Parametrised successor of the core/MMU/memory interface glue. It sits between the MMU request side and the memory bus, and tracks every outstanding read in one ordered tag queue. Each tag carries a type (core load or page-walk) plus its MMU flags, so each memory response is steered to either the core return port or the MMU walk return port. New in this generation: configurable depth, flag width and outstanding limit; flush-by-discard of in-flight reads; sticky underflow error.

---
 rtl/mmu_mem_return_router.sv | 218 +++++++++++++++++++++
 tb/tb_mmu_mem_return_router.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_mem_return_router.sv
// Routes memory read responses to the core or the MMU walker using an ordered tag queue.
// Optional build macro MMU_IF_PERF_COUNT_EN enables the 32-bit performance counters.
module mmu_mem_return_router #(
    parameter int P_DEPTH           = 16,
    parameter int P_DEPTH_N         = 4,
    parameter int P_FLAGS_W         = 24,
    parameter int P_MAX_OUTSTANDING = 16
) (
    input  logic                 iCLOCK,
    input  logic                 inRESET,
    input  logic                 iFLUSH,
    input  logic                 iMMU_REQ,
    output logic                 oMMU_LOCK,
    input  logic                 iMMU_STORE_ACK,
    input  logic                 iMMU_WALK,
    input  logic [P_FLAGS_W-1:0] iMMU_FLAGS,
    input  logic [1:0]           iMMU_ORDER,
    input  logic [3:0]           iMMU_MASK,
    input  logic                 iMMU_RW,
    input  logic [31:0]          iMMU_ADDR,
    input  logic [31:0]          iMMU_DATA,
    output logic                 oMEMORY_REQ,
    input  logic                 iMEMORY_LOCK,
    output logic [1:0]           oMEMORY_ORDER,
    output logic [3:0]           oMEMORY_MASK,
    output logic                 oMEMORY_RW,
    output logic [31:0]          oMEMORY_ADDR,
    output logic [31:0]          oMEMORY_DATA,
    input  logic                 iMEMORY_REQ,
    output logic                 oMEMORY_LOCK,
    input  logic [63:0]          iMEMORY_DATA,
    output logic                 oCORE_REQ,
    input  logic                 iCORE_LOCK,
    output logic                 oCORE_STORE_ACK,
    output logic [63:0]          oCORE_DATA,
    output logic [P_FLAGS_W-1:0] oCORE_MMU_FLAGS,
    output logic                 oWALK_VALID,
    input  logic                 iWALK_LOCK,
    output logic [63:0]          oWALK_DATA,
    output logic                 oBUSY,
    output logic                 oERR_UNDERFLOW,
    output logic [31:0]          oPERF_CORE_LOADS,
    output logic [31:0]          oPERF_WALKS,
    output logic [31:0]          oPERF_STALL
);

    localparam int L_CNT_W = P_DEPTH_N + 1;
    localparam int L_ENT_W = P_FLAGS_W + 1;
    localparam logic [L_CNT_W-1:0]   L_CNT_ZERO = L_CNT_W'(0);
    localparam logic [L_CNT_W-1:0]   L_CNT_ONE  = L_CNT_W'(1);
    localparam logic [L_CNT_W-1:0]   L_CNT_MAX  = L_CNT_W'(P_MAX_OUTSTANDING);
    localparam logic [L_CNT_W-1:0]   L_CNT_FULL = L_CNT_W'(P_DEPTH);
    localparam logic [P_DEPTH_N-1:0] L_PTR_ONE  = P_DEPTH_N'(1);

    logic [L_ENT_W-1:0]   r_mem [P_DEPTH];
    logic [P_DEPTH_N-1:0] r_wr_ptr;
    logic [P_DEPTH_N-1:0] r_rd_ptr;
    logic [L_CNT_W-1:0]   r_count;
    logic [L_CNT_W-1:0]   r_discard;
    logic                 r_core_valid;
    logic [63:0]          r_core_data;
    logic [P_FLAGS_W-1:0] r_core_flags;
    logic                 r_walk_valid;
    logic [63:0]          r_walk_data;
    logic                 r_err_underflow;

    logic                 w_mmu_lock;
    logic                 w_accept;
    logic                 w_store_ack;
    logic                 w_push;
    logic                 w_mem_lock;
    logic                 w_resp;
    logic                 w_pop;
    logic                 w_underflow;
    logic                 w_deliver;
    logic                 w_deliver_core;
    logic                 w_deliver_walk;
    logic [L_ENT_W-1:0]   w_head;
    logic [L_CNT_W-1:0]   w_count_nxt;
    logic [L_CNT_W-1:0]   w_discard_nxt;

    // Issue-side handshake, store ack and response-side handshake decode.
    always_comb begin
        w_mmu_lock     = iMEMORY_LOCK || (r_count == L_CNT_MAX) || (r_count == L_CNT_FULL);
        w_accept       = iMMU_REQ && !w_mmu_lock;
        w_store_ack    = w_accept && iMMU_STORE_ACK;
        w_push         = w_accept && !iMMU_STORE_ACK;
        w_mem_lock     = w_store_ack || iCORE_LOCK || iWALK_LOCK;
        w_resp         = iMEMORY_REQ && !w_mem_lock;
        w_pop          = w_resp && (r_count != L_CNT_ZERO);
        w_underflow    = w_resp && (r_count == L_CNT_ZERO);
        w_head         = r_mem[r_rd_ptr];
        // Flushed entries always sit at the head, so a nonzero discard count drops this pop.
        w_deliver      = w_pop && (r_discard == L_CNT_ZERO);
        w_deliver_core = w_deliver && !w_head[P_FLAGS_W];
        w_deliver_walk = w_deliver && w_head[P_FLAGS_W];
    end

    // Occupancy and discard bookkeeping for the next cycle.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + L_CNT_ONE;
            2'b01:   w_count_nxt = r_count - L_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
        w_discard_nxt = r_discard;
        if (iFLUSH) begin
            w_discard_nxt = r_count - (w_pop ? L_CNT_ONE : L_CNT_ZERO);
        end else if (w_pop && (r_discard != L_CNT_ZERO)) begin
            w_discard_nxt = r_discard - L_CNT_ONE;
        end else begin
            w_discard_nxt = r_discard;
        end
    end

    // Tag queue storage, pointers, counters and sticky underflow flag.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            for (int i = 0; i < P_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_discard       <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {iMMU_WALK, iMMU_FLAGS};
                r_wr_ptr        <= r_wr_ptr + L_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
            end
            r_count         <= w_count_nxt;
            r_discard       <= w_discard_nxt;
            r_err_underflow <= r_err_underflow || w_underflow;
        end
    end

    // Core return register: holds under lock, otherwise loads or drops its valid.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_core_valid <= 1'b0;
            r_core_data  <= '0;
            r_core_flags <= '0;
        end else if (iCORE_LOCK) begin
            r_core_valid <= r_core_valid;
        end else if (w_deliver_core) begin
            r_core_valid <= 1'b1;
            r_core_data  <= iMEMORY_DATA;
            r_core_flags <= w_head[P_FLAGS_W-1:0];
        end else begin
            r_core_valid <= 1'b0;
        end
    end

    // Walk return register: same hold/load/clear rule against the walk lock.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_walk_valid <= 1'b0;
            r_walk_data  <= '0;
        end else if (iWALK_LOCK) begin
            r_walk_valid <= r_walk_valid;
        end else if (w_deliver_walk) begin
            r_walk_valid <= 1'b1;
            r_walk_data  <= iMEMORY_DATA;
        end else begin
            r_walk_valid <= 1'b0;
        end
    end

    assign oMMU_LOCK       = w_mmu_lock;
    assign oMEMORY_REQ     = w_accept;
    assign oMEMORY_ORDER   = iMMU_ORDER;
    assign oMEMORY_MASK    = iMMU_MASK;
    assign oMEMORY_RW      = iMMU_RW;
    assign oMEMORY_ADDR    = iMMU_ADDR;
    assign oMEMORY_DATA    = iMMU_DATA;
    assign oMEMORY_LOCK    = w_mem_lock;
    assign oCORE_REQ       = r_core_valid || w_store_ack;
    assign oCORE_STORE_ACK = w_store_ack;
    assign oCORE_DATA      = r_core_data;
    assign oCORE_MMU_FLAGS = r_core_flags;
    assign oWALK_VALID     = r_walk_valid;
    assign oWALK_DATA      = r_walk_data;
    assign oBUSY           = (r_count != L_CNT_ZERO);
    assign oERR_UNDERFLOW  = r_err_underflow;

`ifdef MMU_IF_PERF_COUNT_EN
    logic [31:0] r_perf_core;
    logic [31:0] r_perf_walk;
    logic [31:0] r_perf_stall;

    // Wrapping event counters for delivered returns and issue stalls.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_perf_core  <= 32'd0;
            r_perf_walk  <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            r_perf_core  <= r_perf_core + (w_deliver_core ? 32'd1 : 32'd0);
            r_perf_walk  <= r_perf_walk + (w_deliver_walk ? 32'd1 : 32'd0);
            r_perf_stall <= r_perf_stall + ((iMMU_REQ && w_mmu_lock) ? 32'd1 : 32'd0);
        end
    end

    assign oPERF_CORE_LOADS = r_perf_core;
    assign oPERF_WALKS      = r_perf_walk;
    assign oPERF_STALL      = r_perf_stall;
`else
    assign oPERF_CORE_LOADS = 32'd0;
    assign oPERF_WALKS      = 32'd0;
    assign oPERF_STALL      = 32'd0;
`endif

endmodule

// File: tb/tb_mmu_mem_return_router.sv
// Randomised and directed bench for mmu_mem_return_router against a queue-based reference model.
module tb_mmu_mem_return_router;

    localparam int P_DEPTH   = 8;
    localparam int P_DEPTH_N = 3;
    localparam int P_FLAGS_W = 24;
    localparam int P_MAX     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, mmu_req, store, walk, mmu_rw, mem_lock, mem_req, core_lock, walk_lock;
    logic [23:0] flags;
    logic [1:0]  order;
    logic [3:0]  mask;
    logic [31:0] addr, wdata;
    logic [63:0] mem_rdata;
    logic        o_mmu_lock, o_mem_req, o_mem_rw, o_mem_lock, o_core_req, o_store_ack;
    logic        o_walk_valid, o_busy, o_err;
    logic [1:0]  o_order;
    logic [3:0]  o_mask;
    logic [31:0] o_addr, o_wdata, o_pc, o_pw, o_ps;
    logic [63:0] o_core_data, o_walk_data;
    logic [23:0] o_core_flags;

    always #5 clk = ~clk;

    mmu_mem_return_router #(.P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N), .P_FLAGS_W(P_FLAGS_W),
                            .P_MAX_OUTSTANDING(P_MAX)) dut (
        .iCLOCK(clk), .inRESET(rst_n), .iFLUSH(flush), .iMMU_REQ(mmu_req), .oMMU_LOCK(o_mmu_lock),
        .iMMU_STORE_ACK(store), .iMMU_WALK(walk), .iMMU_FLAGS(flags), .iMMU_ORDER(order),
        .iMMU_MASK(mask), .iMMU_RW(mmu_rw), .iMMU_ADDR(addr), .iMMU_DATA(wdata),
        .oMEMORY_REQ(o_mem_req), .iMEMORY_LOCK(mem_lock), .oMEMORY_ORDER(o_order),
        .oMEMORY_MASK(o_mask), .oMEMORY_RW(o_mem_rw), .oMEMORY_ADDR(o_addr), .oMEMORY_DATA(o_wdata),
        .iMEMORY_REQ(mem_req), .oMEMORY_LOCK(o_mem_lock), .iMEMORY_DATA(mem_rdata),
        .oCORE_REQ(o_core_req), .iCORE_LOCK(core_lock), .oCORE_STORE_ACK(o_store_ack),
        .oCORE_DATA(o_core_data), .oCORE_MMU_FLAGS(o_core_flags), .oWALK_VALID(o_walk_valid),
        .iWALK_LOCK(walk_lock), .oWALK_DATA(o_walk_data), .oBUSY(o_busy), .oERR_UNDERFLOW(o_err),
        .oPERF_CORE_LOADS(o_pc), .oPERF_WALKS(o_pw), .oPERF_STALL(o_ps)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: outstanding reads as a queue; a flush marks every entry present at that moment.
    typedef struct {
        bit          walk;
        logic [23:0] flags;
        bit          discard;
    } ent_t;

    ent_t        q[$];
    bit          m_core_v, m_walk_v, m_err;
    logic [63:0] m_core_d, m_walk_d;
    logic [23:0] m_core_f;
    logic [31:0] m_pc, m_pw, m_ps;

    task automatic model_reset();
        q.delete();
        m_core_v = 1'b0; m_walk_v = 1'b0; m_err = 1'b0;
        m_core_d = '0; m_walk_d = '0; m_core_f = '0;
        m_pc = '0; m_pw = '0; m_ps = '0;
    endtask

    task automatic set_in(input bit req, input bit st, input bit wk, input logic [23:0] fl,
                          input bit mreq, input logic [63:0] md);
        mmu_req = req; store = st; walk = wk; flags = fl; mem_req = mreq; mem_rdata = md;
        flush = 1'b0; mem_lock = 1'b0; core_lock = 1'b0; walk_lock = 1'b0;
        order = 2'($urandom); mask = 4'($urandom); mmu_rw = 1'($urandom);
        addr = $urandom; wdata = $urandom;
    endtask

    // Entered just after a falling edge with inputs set; returns at the next falling edge.
    task automatic step();
        int   sz;
        bit   e_lock, e_acc, e_st, e_mlock, e_resp, d_core, d_walk;
        ent_t e;
        logic [23:0] d_flags;
        #1;
        sz      = q.size();
        e_lock  = mem_lock || (sz >= P_MAX) || (sz >= P_DEPTH);
        e_acc   = mmu_req && !e_lock;
        e_st    = e_acc && store;
        e_mlock = e_st || core_lock || walk_lock;
        e_resp  = mem_req && !e_mlock;
        check_eq("mmu_lock", o_mmu_lock, e_lock);
        check_eq("mem_req", o_mem_req, e_acc);
        check_eq("mem_lock", o_mem_lock, e_mlock);
        check_eq("core_req", o_core_req, m_core_v || e_st);
        check_eq("store_ack", o_store_ack, e_st);
        check_eq("core_data", o_core_data, m_core_d);
        check_eq("core_flags", o_core_flags, m_core_f);
        check_eq("walk_valid", o_walk_valid, m_walk_v);
        check_eq("walk_data", o_walk_data, m_walk_d);
        check_eq("busy", o_busy, sz != 0);
        check_eq("err", o_err, m_err);
        check_eq("pass", {o_order, o_mask, o_mem_rw, o_addr, o_wdata}, {order, mask, mmu_rw, addr, wdata});
`ifdef MMU_IF_PERF_COUNT_EN
        check_eq("perf", {o_pc, o_pw}, {m_pc, m_pw});
        check_eq("perf_stall", o_ps, m_ps);
`else
        check_eq("perf", {o_pc, o_pw}, 64'd0);
        check_eq("perf_stall", o_ps, 32'd0);
`endif
        @(posedge clk);
        d_core = 1'b0; d_walk = 1'b0; d_flags = '0;
        if (e_resp) begin
            if (sz == 0) begin
                m_err = 1'b1;
            end else begin
                e = q.pop_front();
                if (!e.discard) begin
                    if (e.walk) d_walk = 1'b1;
                    else begin d_core = 1'b1; d_flags = e.flags; end
                end
            end
        end
        if (flush) foreach (q[i]) q[i].discard = 1'b1;
        if (e_acc && !store) q.push_back('{walk: walk, flags: flags, discard: 1'b0});
        if (!core_lock) begin
            m_core_v = d_core;
            if (d_core) begin m_core_d = mem_rdata; m_core_f = d_flags; end
        end
        if (!walk_lock) begin
            m_walk_v = d_walk;
            if (d_walk) m_walk_d = mem_rdata;
        end
        m_pc = m_pc + 32'(d_core);
        m_pw = m_pw + 32'(d_walk);
        m_ps = m_ps + 32'(mmu_req && e_lock);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 64'd0);
        rst_n = 1'b0;
        model_reset();
        #2;
        check_eq("rst_outs", {o_mmu_lock, o_mem_req, o_mem_lock, o_core_req, o_store_ack,
                              o_walk_valid, o_busy, o_err}, 8'd0);
        check_eq("rst_data", {o_core_data, o_walk_data} == '0, 1'b1);
        check_eq("rst_flags", o_core_flags, 24'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, {$urandom, $urandom});
            step();
        end
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 64'd0);
        step();
        check_eq("drained", o_busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        @(negedge clk);
        apply_reset();

        // Single core load returns data and flags one cycle after the response.
        set_in(1'b1, 1'b0, 1'b0, 24'h000123, 1'b0, 64'd0); addr = 32'h1000; step();
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'hA5); step();
        check_eq("tp1_req", {o_core_req, o_walk_valid}, 2'b10);
        check_eq("tp1_data", o_core_data, 64'hA5);
        check_eq("tp1_flags", o_core_flags, 24'h000123);

        // Walk, core, walk ordering.
        set_in(1'b1, 1'b0, 1'b1, 24'h1, 1'b0, 64'd0); step();
        set_in(1'b1, 1'b0, 1'b0, 24'h2, 1'b0, 64'd0); step();
        set_in(1'b1, 1'b0, 1'b1, 24'h3, 1'b0, 64'd0); step();
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'hD0); step();
        check_eq("tp2_w0", {o_walk_valid, o_core_req, o_walk_data}, {2'b10, 64'hD0});
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'hD1); step();
        check_eq("tp2_c1", {o_walk_valid, o_core_req, o_core_data}, {2'b01, 64'hD1});
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'hD2); step();
        check_eq("tp2_w2", {o_walk_valid, o_core_req, o_walk_data}, {2'b10, 64'hD2});
        check_eq("tp2_busy", o_busy, 1'b0);

        // Outstanding limit: four accepted, fifth waits for the first pop.
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 24'(i), 1'b0, 64'd0); step();
        end
        #1 check_eq("tp3_lock", o_mmu_lock, 1'b1);
        set_in(1'b1, 1'b0, 1'b0, 24'h5, 1'b1, 64'h11); step();
        mem_req = 1'b0;
        #1 check_eq("tp3_unlock", {o_mmu_lock, o_mem_req}, 2'b01);
        step();
        drain();

        // Store ack coincident with a response: response held off one cycle.
        set_in(1'b1, 1'b0, 1'b0, 24'h77, 1'b0, 64'd0); step();
        set_in(1'b1, 1'b1, 1'b0, 24'd0, 1'b1, 64'hBEEF);
        #1 check_eq("tp4_ack", {o_core_req, o_store_ack, o_mem_lock}, 3'b111);
        step();
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'hBEEF); step();
        check_eq("tp4_pop", {o_core_req, o_core_data}, {1'b1, 64'hBEEF});

        // Flush discards three outstanding loads but not the one issued afterwards.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'(i), 24'(i), 1'b0, 64'd0); step();
        end
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 64'd0); flush = 1'b1; step();
        set_in(1'b1, 1'b0, 1'b0, 24'hABC, 1'b0, 64'd0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'(i + 100)); step();
            check_eq("tp5_drop", {o_core_req, o_walk_valid}, 2'b00);
        end
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'h4444); step();
        check_eq("tp5_keep", {o_core_req, o_core_data, o_core_flags}, {1'b1, 64'h4444, 24'hABC});
        check_eq("tp5_busy", o_busy, 1'b0);

        // Underflow is sticky until reset.
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 64'h9); step();
        set_in(1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 64'd0); step(); step();
        check_eq("tp6_sticky", {o_err, o_busy}, 2'b10);
        apply_reset();
        check_eq("tp6_clear", o_err, 1'b0);

        // Random traffic, two phases separated by an asynchronous reset mid-stream.
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 2500; c++) begin
                set_in(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom),
                       24'($urandom), 1'b0, {$urandom, $urandom});
                mem_req   = (q.size() != 0 || ph == 1) ? ($urandom_range(0, 9) < 5) : 1'b0;
                mem_lock  = $urandom_range(0, 9) == 0;
                core_lock = $urandom_range(0, 9) == 0;
                walk_lock = $urandom_range(0, 9) == 0;
                flush     = $urandom_range(0, 39) == 0;
                step();
            end
            apply_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
